// File: rtl/key_load_ctrl_pkg.sv
// Shared definitions for the key loader: FSM states, default geometry and
// the XOR-fold checksum applied to the staged key.
package key_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_KEY,
        SHIFT_CHK,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam int unsigned DEF_KEY_W   = 32;
    localparam int unsigned DEF_CHK_W   = 8;
    localparam int unsigned DEF_TIMEOUT = 255;

    localparam int unsigned MAX_KEY_W = 256;
    localparam int unsigned MAX_CHK_W = 64;

    // XOR of all chk_w-bit slices of the low key_w bits of key.
    function automatic logic [MAX_CHK_W-1:0] key_checksum(
        input logic [MAX_KEY_W-1:0] key,
        input int unsigned          key_w,
        input int unsigned          chk_w
    );
        logic [MAX_KEY_W-1:0] acc;
        acc = '0;
        for (int unsigned s = 0; s < key_w; s += chk_w) begin
            acc ^= key >> s;
        end
        return MAX_CHK_W'(acc) & ~({MAX_CHK_W{1'b1}} << chk_w);
    endfunction

endpackage

// File: rtl/key_load_ctrl_if.sv
// Bus between a key source / locked netlist and the key loader.
interface key_load_ctrl_if
    import key_ctrl_pkg::*;
#(
    parameter int unsigned KEY_W = DEF_KEY_W
);
    logic             start;
    logic             ser_data;
    logic             ser_valid;
    logic [KEY_W-1:0] ckt_out_i;
    logic [KEY_W-1:0] key_out;
    logic [KEY_W-1:0] ckt_out_o;
    logic             key_valid;
    logic             busy;
    logic             err;

    modport master (
        output start, ser_data, ser_valid, ckt_out_i,
        input  key_out, ckt_out_o, key_valid, busy, err
    );

    modport slave (
        input  start, ser_data, ser_valid, ckt_out_i,
        output key_out, ckt_out_o, key_valid, busy, err
    );
endinterface

// File: rtl/key_load_ctrl_shift_reg.sv
// Staging register for the serial key plus its received checksum, filled
// LSB first under a shared bit counter that wraps between the two phases.
module key_shift_reg #(
    parameter int unsigned KEY_W = 32,
    parameter int unsigned CHK_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_shift_key,
    input  logic             i_shift_chk,
    input  logic             i_bit,
    output logic [KEY_W-1:0] o_stage,
    output logic [CHK_W-1:0] o_chk,
    output logic             o_key_last,
    output logic             o_chk_last
);
    localparam int unsigned CW = $clog2(KEY_W + 1);
    localparam logic [CW-1:0] KEY_LAST = CW'(KEY_W - 1);
    localparam logic [CW-1:0] CHK_LAST = CW'(CHK_W - 1);

    logic [KEY_W-1:0] r_stage;
    logic [CHK_W-1:0] r_chk;
    logic [CW-1:0]    r_cnt;

    // Bits start cleared, so OR-ing the beat into position cnt is a write.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_stage <= '0;
            r_chk   <= '0;
            r_cnt   <= '0;
        end else if (i_shift_key) begin
            r_stage <= r_stage | (KEY_W'(i_bit) << r_cnt);
            r_cnt   <= (r_cnt == KEY_LAST) ? '0 : r_cnt + 1'b1;
        end else if (i_shift_chk) begin
            r_chk   <= r_chk | (CHK_W'(i_bit) << r_cnt);
            r_cnt   <= (r_cnt == CHK_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_stage    = r_stage;
    assign o_chk      = r_chk;
    assign o_key_last = (r_cnt == KEY_LAST);
    assign o_chk_last = (r_cnt == CHK_LAST);

endmodule

// File: rtl/key_load_ctrl.sv
// Serial key loader for a logic-locked netlist: receives key and checksum,
// commits the key only on checksum match, and gates the netlist outputs.
module key_load_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int unsigned KEY_W   = DEF_KEY_W,
    parameter int unsigned CHK_W   = DEF_CHK_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input logic            clk,
    input logic            rst,
    key_load_ctrl_if.slave bus
);
    localparam int unsigned IW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] TMO = IW'(TIMEOUT);

    state_t           r_state;
    logic [KEY_W-1:0] r_key_out;
    logic             r_key_valid;
    logic             r_err;
    logic             r_busy;
    logic [IW-1:0]    r_idle;

    logic             w_shifting;
    logic             w_start_go;
    logic             w_beat;
    logic             w_key_last;
    logic             w_chk_last;
    logic             w_match;
    logic [KEY_W-1:0] w_stage;
    logic [CHK_W-1:0] w_chk;
    logic [CHK_W-1:0] w_exp;
    logic [IW-1:0]    w_idle_inc;

    assign w_shifting = (r_state == SHIFT_KEY) || (r_state == SHIFT_CHK);
    assign w_start_go = bus.start && (r_state inside {IDLE, DONE, ERROR});
    assign w_beat     = bus.ser_valid && w_shifting;
    assign w_exp      = CHK_W'(key_checksum(MAX_KEY_W'(w_stage), KEY_W, CHK_W));
    assign w_match    = (w_exp == w_chk);
    assign w_idle_inc = (r_idle == TMO) ? r_idle : r_idle + 1'b1;

    key_shift_reg #(
        .KEY_W(KEY_W),
        .CHK_W(CHK_W)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_start_go),
        .i_shift_key(w_beat && (r_state == SHIFT_KEY)),
        .i_shift_chk(w_beat && (r_state == SHIFT_CHK)),
        .i_bit      (bus.ser_data),
        .o_stage    (w_stage),
        .o_chk      (w_chk),
        .o_key_last (w_key_last),
        .o_chk_last (w_chk_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_key_out   <= '0;
            r_key_valid <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_idle      <= '0;
        end else begin
            case (r_state)
                IDLE, DONE, ERROR: begin
                    if (bus.start) begin
                        r_key_out   <= '0;
                        r_key_valid <= 1'b0;
                        r_err       <= 1'b0;
                        r_idle      <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= SHIFT_KEY;
                    end
                end
                SHIFT_KEY, SHIFT_CHK: begin
                    if (w_beat) begin
                        r_idle <= '0;
                        if (r_state == SHIFT_KEY && w_key_last) r_state <= SHIFT_CHK;
                        if (r_state == SHIFT_CHK && w_chk_last) r_state <= CHECK;
                    end else begin
                        r_idle <= w_idle_inc;
                        if (w_idle_inc == TMO) begin
                            r_state     <= ERROR;
                            r_err       <= 1'b1;
                            r_busy      <= 1'b0;
                            r_key_valid <= 1'b0;
                            r_key_out   <= '0;
                        end
                    end
                end
                CHECK: begin
                    r_busy <= 1'b0;
                    if (w_match) begin
                        r_key_out   <= w_stage;
                        r_key_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_key_out   <= '0;
                        r_key_valid <= 1'b0;
                        r_err       <= 1'b1;
                        r_state     <= ERROR;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.key_out   = r_key_out;
    assign bus.key_valid = r_key_valid;
    assign bus.err       = r_err;
    assign bus.busy      = r_busy;
    assign bus.ckt_out_o = r_key_valid ? bus.ckt_out_i : '0;

endmodule
